// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// The state encoding and the latched command shape are defined here.
package mem_arb_pkg;

    localparam int TIMEOUT_DEFAULT = 16;
    localparam int CTR_W           = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    // Command latched at grant; drives the memory port for the whole BUSY phase.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

    function automatic logic is_busy(input arb_state_t s);
        return (s == IF_BUSY) || (s == DM_BUSY);
    endfunction

endpackage

// File: rtl/mem_arbiter_timeout_ctr.sv
// Access watchdog: counts BUSY cycles without an ack and flags the cycle
// on which the count would reach LIMIT.
module timeout_ctr
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CTR_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CTR_W'(1);
        end
    end

    // Expiry is qualified by en, so an ack on the final cycle always wins.
    assign expired = en && (cnt == CTR_W'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one memory port.
// Data wins ties; each access runs grant -> BUSY -> one-cycle RESP -> IDLE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall
);

    arb_state_t state;
    mem_cmd_t   cmd;
    logic       grant;
    logic       busy;
    logic       expired;

    assign busy  = is_busy(state);
    assign grant = (state == IDLE) && (dm_req || if_req);

    timeout_ctr #(.LIMIT(TIMEOUT)) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (grant),
        .en      (busy && !mem_ack),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cmd      <= '0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            resp_err <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            resp_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (dm_req) begin
                        state     <= DM_BUSY;
                        cmd.we    <= dm_we;
                        cmd.addr  <= dm_addr;
                        cmd.wdata <= dm_wdata;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                    end else if (if_req) begin
                        state     <= IF_BUSY;
                        cmd.we    <= 1'b0;
                        cmd.addr  <= if_addr;
                        cmd.wdata <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                    end
                end
                IF_BUSY, DM_BUSY: begin
                    if (mem_ack || expired) begin
                        state    <= RESP;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        resp_err <= !mem_ack;
                        if (state == IF_BUSY) begin
                            if_valid <= 1'b1;
                            if_rdata <= mem_ack ? mem_rdata : 32'h0;
                        end else begin
                            dm_valid <= 1'b1;
                            // A completed store keeps the last load result.
                            if (!mem_ack)
                                dm_rdata <= 32'h0;
                            else if (!cmd.we)
                                dm_rdata <= mem_rdata;
                        end
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;
    assign stall     = (if_req && !if_valid) || (dm_req && !dm_valid);

endmodule
